// File: rtl/bnn_neuron_accum.sv
// bnn_neuron_accum: accumulates popcount chunks of a binary neuron vector,
// saturates the sum and thresholds it into a binary activation.
module bnn_neuron_accum #(
    parameter int CWIDTH = 4,
    parameter int AWIDTH = 8,
    parameter int NCHUNK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CWIDTH-1:0] in_cnt,
    input  logic              in_last,
    input  logic [AWIDTH-1:0] threshold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] out_sum,
    output logic              out_act
);
    localparam int NW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam int SW = (AWIDTH > CWIDTH ? AWIDTH : CWIDTH) + 1;
    localparam logic [SW-1:0] MAX = (SW'(1) << AWIDTH) - SW'(1);

    typedef enum logic {ACC, OUT} state_t;

    state_t            state;
    logic [AWIDTH-1:0] acc;
    logic [AWIDTH-1:0] acc_next;
    logic [NW-1:0]     cnt;
    logic [SW-1:0]     sum;
    logic              close;

    // one extra bit of headroom makes the saturation test a plain compare
    always_comb begin
        sum      = SW'(acc) + SW'(in_cnt);
        acc_next = sum > MAX ? {AWIDTH{1'b1}} : sum[AWIDTH-1:0];
        close    = in_last || cnt == NW'(NCHUNK - 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ACC;
            acc       <= '0;
            cnt       <= '0;
            out_sum   <= '0;
            out_act   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else if (state == ACC) begin
            if (in_valid && close) begin
                out_sum   <= acc_next;
                out_act   <= acc_next >= threshold;
                acc       <= '0;
                cnt       <= '0;
                state     <= OUT;
                in_ready  <= 1'b0;
                out_valid <= 1'b1;
            end else if (in_valid) begin
                acc <= acc_next;
                cnt <= cnt + 1'b1;
            end
        end else if (out_ready) begin
            state     <= ACC;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end
    end
endmodule
